// File: rtl/conv_sequencer.sv
// Convolution-as-GEMM sequencer: walks the HWC operand space, waits for the
// requantised results, then streams the result SRAM out over AXI-Stream.
module conv_sequencer #(
    parameter int ADDR_WIDTH         = 13,
    parameter int DATA_WIDTH         = 32,
    parameter int MAX_CHANNELS       = 64,
    parameter int NUM_CHANNELS_WIDTH = $clog2(MAX_CHANNELS + 1),
    parameter int SRAM_LATENCY       = 1
) (
    input  logic                          s00_axis_aclk,
    input  logic                          s00_axis_aresetn,
    input  logic                          start,
    input  logic [ADDR_WIDTH-1:0]         img_row,
    input  logic [ADDR_WIDTH-1:0]         img_col,
    input  logic [ADDR_WIDTH-1:0]         ker_row,
    input  logic [ADDR_WIDTH-1:0]         ker_col,
    input  logic [NUM_CHANNELS_WIDTH-1:0] num_channels,
    input  logic                          stride2,
    output logic                          busy,
    output logic                          done,
    output logic                          cfg_err,
    output logic                          rd_en,
    output logic [ADDR_WIDTH-1:0]         img_addr,
    output logic [ADDR_WIDTH-1:0]         ker_addr,
    output logic                          mac_first,
    output logic                          mac_last,
    input  logic                          res_valid,
    output logic                          out_rd_en,
    output logic [ADDR_WIDTH-1:0]         out_rd_addr,
    input  logic [DATA_WIDTH-1:0]         out_rd_data,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [NUM_CHANNELS_WIDTH-1:0] m_axis_tuser
);
    localparam int NW    = 2 * ADDR_WIDTH;
    localparam int DEPTH = 1 + SRAM_LATENCY;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam logic [CW:0]   DEPTH_V = (CW + 1)'(DEPTH);
    localparam logic [PW-1:0] PTR_MAX = PW'(DEPTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_COMPUTE, S_DRAIN, S_OUTPUT} state_t;
    state_t state_q, state_d;

    logic                          armed_q, done_q, cfg_err_q, s2_q;
    logic [ADDR_WIDTH-1:0]         ir_q, ic_q, kr_q, kc_q, or_q, oc_q;
    logic [NUM_CHANNELS_WIDTH-1:0] ch_q, c_q;
    logic [ADDR_WIDTH-1:0]         kx_q, ky_q, ox_q, oy_q;
    logic [NW-1:0]                 n_q, res_cnt_q, rd_cnt_q, beat_q;
    logic [SRAM_LATENCY-1:0]       first_sr, last_sr, vld_sr;
    logic [CW-1:0]                 infl_q, cnt_q;
    logic [PW-1:0]                 wp_q, rp_q;
    logic [DATA_WIDTH-1:0]         mem_q [DEPTH];

    logic start_acc, cfg_bad, c_end, kx_end, ky_end, ox_end, oy_end, last_read;
    logic first_now, last_now, hs, beat_last, arrive;
    logic [ADDR_WIDTH-1:0] or_calc, oc_calc, iy, ix;
    logic [CW:0] occ;

    assign start_acc = (state_q == S_IDLE) && start && armed_q;
    assign or_calc   = ((ir_q - kr_q) >> s2_q) + ADDR_WIDTH'(1);
    assign oc_calc   = ((ic_q - kc_q) >> s2_q) + ADDR_WIDTH'(1);
    assign cfg_bad   = (kr_q > ir_q) || (kc_q > ic_q) || (ir_q == '0) || (ic_q == '0) ||
                       (kr_q == '0) || (kc_q == '0) || (ch_q == '0) ||
                       (ch_q > NUM_CHANNELS_WIDTH'(MAX_CHANNELS));

    assign c_end     = c_q  == ch_q - NUM_CHANNELS_WIDTH'(1);
    assign kx_end    = kx_q == kc_q - ADDR_WIDTH'(1);
    assign ky_end    = ky_q == kr_q - ADDR_WIDTH'(1);
    assign ox_end    = ox_q == oc_q - ADDR_WIDTH'(1);
    assign oy_end    = oy_q == or_q - ADDR_WIDTH'(1);
    assign last_read = c_end && kx_end && ky_end && ox_end && oy_end;

    // Address arithmetic modulo 2^ADDR_WIDTH equals the full-width result truncated.
    assign iy        = (oy_q << s2_q) + ky_q;
    assign ix        = (ox_q << s2_q) + kx_q;
    assign rd_en     = (state_q == S_COMPUTE);
    assign img_addr  = rd_en ? (iy * ic_q + ix) * ADDR_WIDTH'(ch_q) + ADDR_WIDTH'(c_q) : '0;
    assign ker_addr  = rd_en ? (ky_q * kc_q + kx_q) * ADDR_WIDTH'(ch_q) + ADDR_WIDTH'(c_q) : '0;
    assign first_now = rd_en && (ky_q == '0) && (kx_q == '0) && (c_q == '0);
    assign last_now  = rd_en && ky_end && kx_end && c_end;
    assign mac_first = first_sr[SRAM_LATENCY-1];
    assign mac_last  = last_sr[SRAM_LATENCY-1];

    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;
    assign cfg_err       = cfg_err_q;
    assign hs            = m_axis_tvalid && m_axis_tready;
    assign beat_last     = beat_q == n_q - NW'(1);
    assign arrive        = vld_sr[SRAM_LATENCY-1];
    assign occ           = {1'b0, infl_q} + {1'b0, cnt_q} - {{CW{1'b0}}, hs};
    assign out_rd_en     = (state_q == S_OUTPUT) && (rd_cnt_q != n_q) && (occ < DEPTH_V);
    assign out_rd_addr   = rd_cnt_q[ADDR_WIDTH-1:0];
    assign m_axis_tvalid = (cnt_q != '0);
    assign m_axis_tdata  = mem_q[rp_q];
    assign m_axis_tlast  = m_axis_tvalid && beat_last;
    assign m_axis_tuser  = ch_q;

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) state_q <= S_IDLE;
        else                   state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start_acc) state_d = S_CHECK;
            S_CHECK:   state_d = cfg_bad ? S_IDLE : S_COMPUTE;
            S_COMPUTE: if (last_read) state_d = S_DRAIN;
            S_DRAIN:   if (res_cnt_q == n_q) state_d = S_OUTPUT;
            S_OUTPUT:  if (hs && beat_last) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // armed_q holds off start until the first edge after reset release.
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            armed_q <= 1'b0; done_q <= 1'b0; cfg_err_q <= 1'b0; s2_q <= 1'b0;
            ir_q <= '0; ic_q <= '0; kr_q <= '0; kc_q <= '0; ch_q <= '0;
            or_q <= '0; oc_q <= '0; n_q <= '0; res_cnt_q <= '0;
        end else begin
            armed_q <= 1'b1;
            done_q  <= (state_q == S_OUTPUT) && hs && beat_last;
            if (start_acc) begin
                ir_q <= img_row; ic_q <= img_col; kr_q <= ker_row; kc_q <= ker_col;
                ch_q <= num_channels; s2_q <= stride2; cfg_err_q <= 1'b0; res_cnt_q <= '0;
            end else if ((state_q == S_COMPUTE || state_q == S_DRAIN) && res_valid &&
                         res_cnt_q != n_q) begin
                res_cnt_q <= res_cnt_q + NW'(1);
            end
            if (state_q == S_CHECK) begin
                or_q <= or_calc;
                oc_q <= oc_calc;
                n_q  <= NW'(or_calc) * NW'(oc_calc);
                if (cfg_bad) cfg_err_q <= 1'b1;
            end
        end
    end

    // Loop nest, innermost first: c, kx, ky, ox, oy.
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            c_q <= '0; kx_q <= '0; ky_q <= '0; ox_q <= '0; oy_q <= '0;
        end else if (start_acc) begin
            c_q <= '0; kx_q <= '0; ky_q <= '0; ox_q <= '0; oy_q <= '0;
        end else if (rd_en) begin
            if (!c_end) c_q <= c_q + NUM_CHANNELS_WIDTH'(1);
            else begin
                c_q <= '0;
                if (!kx_end) kx_q <= kx_q + ADDR_WIDTH'(1);
                else begin
                    kx_q <= '0;
                    if (!ky_end) ky_q <= ky_q + ADDR_WIDTH'(1);
                    else begin
                        ky_q <= '0;
                        if (!ox_end) ox_q <= ox_q + ADDR_WIDTH'(1);
                        else begin
                            ox_q <= '0;
                            oy_q <= oy_end ? '0 : oy_q + ADDR_WIDTH'(1);
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            first_sr <= '0; last_sr <= '0;
        end else begin
            first_sr[0] <= first_now;
            last_sr[0]  <= last_now;
            for (int i = 1; i < SRAM_LATENCY; i++) begin
                first_sr[i] <= first_sr[i-1];
                last_sr[i]  <= last_sr[i-1];
            end
        end
    end

    // Result readout: in-flight reads plus buffered beats never exceed the buffer depth.
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            rd_cnt_q <= '0; beat_q <= '0; vld_sr <= '0; infl_q <= '0; cnt_q <= '0;
            wp_q <= '0; rp_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (start_acc) begin
                rd_cnt_q <= '0;
                beat_q   <= '0;
            end else begin
                if (out_rd_en) rd_cnt_q <= rd_cnt_q + NW'(1);
                if (hs)        beat_q   <= beat_q + NW'(1);
            end
            vld_sr[0] <= out_rd_en;
            for (int i = 1; i < SRAM_LATENCY; i++) vld_sr[i] <= vld_sr[i-1];
            infl_q <= infl_q + CW'(out_rd_en) - CW'(arrive);
            cnt_q  <= cnt_q + CW'(arrive) - CW'(hs);
            if (arrive) begin
                mem_q[wp_q] <= out_rd_data;
                wp_q        <= (wp_q == PTR_MAX) ? '0 : wp_q + PW'(1);
            end
            if (hs) rp_q <= (rp_q == PTR_MAX) ? '0 : rp_q + PW'(1);
        end
    end
endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer: operand address walk, MAC tag alignment,
// config errors, back-pressured result streaming and reset recovery.
module tb_conv_sequencer;
    localparam int AW = 13, DW = 32, MAXC = 64, NCW = 7, LAT = 2;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic start = 0, stride2 = 0, res_valid = 0, m_axis_tready = 1;
    logic [AW-1:0] img_row = 0, img_col = 0, ker_row = 0, ker_col = 0;
    logic [NCW-1:0] num_channels = 0;
    logic busy, done, cfg_err, rd_en, mac_first, mac_last, out_rd_en;
    logic m_axis_tvalid, m_axis_tlast;
    logic [AW-1:0] img_addr, ker_addr, out_rd_addr;
    logic [DW-1:0] out_rd_data, m_axis_tdata;
    logic [NCW-1:0] m_axis_tuser;

    conv_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_CHANNELS(MAXC),
                     .NUM_CHANNELS_WIDTH(NCW), .SRAM_LATENCY(LAT)) dut (
        .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n), .start(start),
        .img_row(img_row), .img_col(img_col), .ker_row(ker_row), .ker_col(ker_col),
        .num_channels(num_channels), .stride2(stride2), .busy(busy), .done(done),
        .cfg_err(cfg_err), .rd_en(rd_en), .img_addr(img_addr), .ker_addr(ker_addr),
        .mac_first(mac_first), .mac_last(mac_last), .res_valid(res_valid),
        .out_rd_en(out_rd_en), .out_rd_addr(out_rd_addr), .out_rd_data(out_rd_data),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser));

    int tests = 0, fails = 0;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Geometry of the run in progress, read by the monitor.
    int g_ic = 1, g_kr = 1, g_kc = 1, g_ch = 1, g_s2 = 0, g_oc = 1, exp_n = 1, exp_reads = 1;
    logic [7:0] run_tag = 8'h10;
    bit rnd_ready = 0;

    function automatic logic [DW-1:0] mkd(input logic [7:0] tag, input int a);
        return {tag, 8'h3C, a[15:0]};
    endfunction

    // Result SRAM: returns tagged data LAT cycles after a read, junk otherwise.
    logic [DW-1:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= out_rd_en ? mkd(run_tag, int'(out_rd_addr)) : 32'hDEAD_BEEF;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign out_rd_data = pipe[LAT-1];

    logic [15:0] lfsr = 16'hACE1;
    initial forever begin
        @(posedge clk); #1;
        lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        m_axis_tready = rnd_ready ? lfsr[0] : 1'b1;
    end

    int rd_seen, addr_mism, mf_cnt, ml_cnt, align_mism, beats, data_mism, last_mism;
    int tlast_cnt, stab_mism, done_cnt, first_beat_cyc, last_beat_cyc, cyc = 0;
    logic [AW-1:0] addr_log [32];
    logic [NCW-1:0] tuser_seen;
    bit eh_f [4], eh_l [4];
    bit stall_prev = 0;
    logic [DW-1:0] prev_data;
    logic prev_last;

    task automatic clear_counters();
        rd_seen = 0; addr_mism = 0; mf_cnt = 0; ml_cnt = 0; align_mism = 0; beats = 0;
        data_mism = 0; last_mism = 0; tlast_cnt = 0; stab_mism = 0; done_cnt = 0;
        first_beat_cyc = 0; last_beat_cyc = 0; tuser_seen = '0;
    endtask

    always @(negedge clk) begin : mon
        int k, c, t, kx, ky, ox, oy, ei, ek;
        bit ef, el;
        cyc++;
        if (mac_first !== eh_f[LAT-1] || mac_last !== eh_l[LAT-1]) align_mism++;
        if (mac_first) mf_cnt++;
        if (mac_last) ml_cnt++;
        ef = 0; el = 0;
        if (rd_en === 1'b1) begin
            k = rd_seen; c = k % g_ch; t = k / g_ch; kx = t % g_kc; t = t / g_kc;
            ky = t % g_kr; t = t / g_kr; ox = t % g_oc; oy = t / g_oc;
            ei = ((((oy << g_s2) + ky) * g_ic + (ox << g_s2) + kx) * g_ch + c);
            ek = ((ky * g_kc + kx) * g_ch + c);
            if (img_addr !== ei[AW-1:0] || ker_addr !== ek[AW-1:0]) addr_mism++;
            if (k < 32) addr_log[k] = img_addr;
            ef = (ky == 0 && kx == 0 && c == 0);
            el = (ky == g_kr - 1 && kx == g_kc - 1 && c == g_ch - 1);
            rd_seen++;
        end
        for (int i = 3; i > 0; i--) begin eh_f[i] = eh_f[i-1]; eh_l[i] = eh_l[i-1]; end
        eh_f[0] = ef; eh_l[0] = el;
        if (stall_prev && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data ||
                           m_axis_tlast !== prev_last)) stab_mism++;
        if (m_axis_tvalid && m_axis_tready) begin
            if (beats == 0) first_beat_cyc = cyc;
            last_beat_cyc = cyc;
            if (m_axis_tdata !== mkd(run_tag, beats)) data_mism++;
            if (m_axis_tlast !== (beats == exp_n - 1)) last_mism++;
            if (m_axis_tlast) tlast_cnt++;
            tuser_seen = m_axis_tuser;
            beats++;
        end
        stall_prev = m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
        prev_last  = m_axis_tlast;
        if (done) done_cnt++;
    end

    task automatic run_conv(input int ir, ic, kr, kc, ch, s2, extra, input bit rnd, poke);
        int to;
        bit poked;
        g_ic = ic; g_kr = kr; g_kc = kc; g_ch = ch; g_s2 = s2;
        g_oc = ((ic - kc) >> s2) + 1;
        exp_n = (((ir - kr) >> s2) + 1) * g_oc;
        exp_reads = exp_n * kr * kc * ch;
        run_tag++;
        clear_counters();
        rnd_ready = rnd;
        @(posedge clk); #1;
        img_row = ir[AW-1:0]; img_col = ic[AW-1:0]; ker_row = kr[AW-1:0]; ker_col = kc[AW-1:0];
        num_channels = ch[NCW-1:0]; stride2 = s2[0]; start = 1;
        @(posedge clk); #1;
        start = 0;
        to = 0;
        while (!(rd_seen >= exp_reads && rd_en == 1'b0) && to < 20000) begin
            @(negedge clk); #1; to++;
        end
        check("reads_timeout", to >= 20000, 0);
        for (int i = 0; i < exp_n + extra; i++) begin @(posedge clk); #1; res_valid = 1; end
        @(posedge clk); #1;
        res_valid = 0;
        to = 0; poked = 0;
        while (done_cnt == 0 && to < 20000) begin
            @(negedge clk); #1; to++;
            if (poke && !poked && beats > 0) begin
                start = 1; ker_row = 1; num_channels = 5; poked = 1;
                @(negedge clk); #1;
                start = 0; ker_row = kr[AW-1:0]; num_channels = ch[NCW-1:0];
            end
        end
        check("done_timeout", to >= 20000, 0);
        repeat (10) @(negedge clk);
        #1;
        check("reads", rd_seen, exp_reads);
        check("addr_mism", addr_mism, 0);
        check("mac_first_cnt", mf_cnt, exp_n);
        check("mac_last_cnt", ml_cnt, exp_n);
        check("mac_align", align_mism, 0);
        check("beats", beats, exp_n);
        check("beat_data", data_mism, 0);
        check("tlast_pos", last_mism, 0);
        check("tlast_cnt", tlast_cnt, 1);
        check("stable_stall", stab_mism, 0);
        check("done_cnt", done_cnt, 1);
        check("busy_end", busy, 0);
        check("tuser", tuser_seen, ch);
        if (!rnd) check("throughput", last_beat_cyc - first_beat_cyc, exp_n - 1);
    endtask

    int bad_cfg [5][5] = '{'{4, 4, 5, 3, 1}, '{4, 4, 3, 5, 1}, '{4, 4, 3, 3, 0},
                           '{4, 4, 3, 3, 65}, '{0, 4, 0, 3, 1}};
    int seq1 [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

    initial begin
        clear_counters();
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_ctrl", {done, cfg_err, rd_en, mac_first, mac_last, out_rd_en}, 0);
        check("rst_axis", {m_axis_tvalid, m_axis_tlast, m_axis_tuser}, 0);
        check("rst_data", {m_axis_tdata, img_addr, ker_addr, out_rd_addr}, 0);
        rst_n = 1;

        // 4x4 image, 3x3 kernel, C=1, stride 1
        run_conv(4, 4, 3, 3, 1, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) check("img_seq", addr_log[i], seq1[i]);

        // 5x5 image, 3x3 kernel, C=2, stride 2; one surplus res_valid pulse
        run_conv(5, 5, 3, 3, 2, 1, 1, 0, 0);
        check("addr_out01", addr_log[18], 4);

        // Illegal geometries
        for (int j = 0; j < 5; j++) begin
            rd_seen = 0;
            @(posedge clk); #1;
            img_row = bad_cfg[j][0][AW-1:0]; img_col = bad_cfg[j][1][AW-1:0];
            ker_row = bad_cfg[j][2][AW-1:0]; ker_col = bad_cfg[j][3][AW-1:0];
            num_channels = bad_cfg[j][4][NCW-1:0]; start = 1;
            @(posedge clk); #1;
            start = 0;
            @(posedge clk); #1;
            check("cfg_err_set", cfg_err, 1);
            check("cfg_err_idle", busy, 0);
            repeat (3) @(negedge clk);
            #1;
            check("cfg_err_noreads", rd_seen, 0);
        end

        // Random back-pressure, start poked mid-output; clears the sticky error
        run_conv(4, 4, 2, 2, 3, 0, 0, 1, 1);
        check("cfg_err_cleared", cfg_err, 0);

        // Reset in the middle of COMPUTE
        g_ic = 4; g_kr = 3; g_kc = 3; g_ch = 1; g_s2 = 0; g_oc = 2; exp_n = 4;
        clear_counters();
        @(posedge clk); #1;
        img_row = 4; img_col = 4; ker_row = 3; ker_col = 3; num_channels = 1; stride2 = 0;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (8) @(negedge clk);
        #1;
        check("mid_compute", rd_en, 1);
        @(negedge clk);
        rst_n = 0;
        #1;
        check("arst_outputs", {busy, rd_en, out_rd_en, m_axis_tvalid, img_addr}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        beats = 0;
        repeat (12) @(negedge clk);
        #1;
        check("start_at_release_ignored", busy, 0);
        check("no_stale_beats", beats, 0);
        run_conv(4, 4, 3, 3, 1, 0, 0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/conv_sequencer.md
CONV_SEQUENCER -- requirements
Module: conv_sequencer

Interface
REQ-001 Parameters (name, default, meaning): ADDR_WIDTH, 13, SRAM address and dimension width; DATA_WIDTH, 32, output sample width; MAX_CHANNELS, 64, channel limit; NUM_CHANNELS_WIDTH, $clog2(MAX_CHANNELS+1), channel-count width; SRAM_LATENCY, 1, SRAM read latency in cycles (1..3).
REQ-002 s00_axis_aclk  in  1  single clock; all logic on rising edge.
REQ-003 s00_axis_aresetn  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  one-cycle request; sampled only in IDLE.
REQ-005 img_row, img_col, ker_row, ker_col  in  ADDR_WIDTH each  layer geometry.
REQ-006 num_channels  in  NUM_CHANNELS_WIDTH  input channels C.
REQ-007 stride2  in  1  0 = stride 1, 1 = stride 2.
REQ-008 busy  out  1  high when state is not IDLE.
REQ-009 done  out  1  one-cycle pulse after the final output beat is accepted.
REQ-010 cfg_err  out  1  sticky config error; cleared by the next accepted start.
REQ-011 rd_en, img_addr, ker_addr  out  1/ADDR_WIDTH/ADDR_WIDTH  GEMM operand read port.
REQ-012 mac_first, mac_last  out  1 each  accumulate clear/finish tags, delayed by SRAM_LATENCY to align with the returned data.
REQ-013 res_valid  in  1  one requantised result written to the result SRAM.
REQ-014 out_rd_en, out_rd_addr  out  1/ADDR_WIDTH  result-SRAM read port.
REQ-015 out_rd_data  in  DATA_WIDTH  valid SRAM_LATENCY cycles after out_rd_en.
REQ-016 m_axis_tdata/tvalid/tready/tlast/tuser  out/out/in/out/out  DATA_WIDTH/1/1/1/NUM_CHANNELS_WIDTH  AXI-Stream result master; tuser = latched num_channels.

Function
REQ-017 States: IDLE, CHECK, COMPUTE, DRAIN, OUTPUT.
REQ-018 IDLE: start latches all configuration inputs; next state CHECK. Configuration changes while busy are ignored.
REQ-019 CHECK (1 cycle): go to IDLE with cfg_err=1 if ker_row>img_row, ker_col>img_col, num_channels==0, num_channels>MAX_CHANNELS, or any dimension==0; otherwise go to COMPUTE.
REQ-020 Output dims: OR = ((img_row-ker_row)>>stride2)+1, OC = ((img_col-ker_col)>>stride2)+1, N = OR*OC.
REQ-021 COMPUTE: issue one read per cycle with rd_en=1. Loop order, innermost first: c, kx, ky, ox, oy.
REQ-022 Addressing is HWC: img_addr = (((oy<<s)+ky)*img_col + (ox<<s)+kx)*C + c; ker_addr = (ky*ker_col+kx)*C + c. Products are computed at full width and truncated to ADDR_WIDTH.
REQ-023 mac_first is asserted when ky=kx=c=0; mac_last when ky=ker_row-1, kx=ker_col-1, c=C-1. Both are delayed by SRAM_LATENCY cycles.
REQ-024 After the last read is issued, deassert rd_en and enter DRAIN. DRAIN waits until the res_valid count equals N.
REQ-025 A res_valid count reaching N during COMPUTE is impossible; if counted past N, the extra pulses are ignored.
REQ-026 OUTPUT: read addresses 0..N-1. Present data on m_axis. tvalid/tdata/tlast change only when the bus is idle or on a cycle with tvalid&&tready.
REQ-027 Output buffer: 1+SRAM_LATENCY entries. Issue out_rd_en only when in-flight reads plus buffered entries are below capacity, so no data is dropped under any tready pattern.
REQ-028 tlast is asserted on beat N-1 only. After that beat's handshake: done=1 for one cycle, then IDLE.
REQ-029 start asserted while busy is ignored. With tready held high, throughput is 1 beat per cycle after the SRAM_LATENCY fill.

Reset
REQ-030 Asynchronous assertion forces IDLE and clears all counters and the buffer. All outputs go to 0: busy, done, cfg_err, rd_en, mac_first, mac_last, out_rd_en, tvalid, tlast, addresses, tdata, tuser.
REQ-031 Reset mid-operation discards all in-flight reads; no m_axis beat follows deassertion until a new start.
REQ-032 Deassertion is used synchronously; the first start is accepted on the second edge after release.

Verification
REQ-033 4x4 image, 3x3 kernel, C=1, stride 1, tready=1 -> 36 reads. img_addr sequence for output (0,0) is 0,1,2,4,5,6,8,9,10. After 4 res_valid pulses: 4 beats at addresses 0..3, tlast on beat 3, then a done pulse.
REQ-034 5x5 image, 3x3 kernel, C=2, stride2=1 -> OR=OC=2. First img_addr for output (0,1) is 4. 72 reads. mac_last pulses 4 times, aligned to SRAM_LATENCY.
REQ-035 ker_row=5, img_row=4 -> cfg_err=1, no rd_en, back to IDLE within 2 cycles. The next valid start clears cfg_err.
REQ-036 OUTPUT with tready toggling pseudo-randomly and SRAM_LATENCY=2 -> all N beats appear in order, with no duplicates and no loss; tdata is stable while tvalid&&!tready.
REQ-037 Reset asserted mid-COMPUTE, then a fresh start -> second run output matches the golden model; no stale beats appear.
REQ-038 start pulsed during OUTPUT -> ignored; the running transfer completes unchanged.
